// File: rtl/msg_pkg.sv
// Shared types, message table and lookup helpers for the message stream arbiter.
package msg_pkg;

    localparam int unsigned MSG_DATA_W = 8;
    localparam int unsigned MSG_IDX_W  = 4;
    localparam int unsigned MSG_A_LEN  = 9;
    localparam int unsigned MSG_B_LEN  = 7;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_STREAM = 2'd1;
    localparam state_t ST_DONE   = 2'd2;

    typedef enum logic {
        MSG_A_ID = 1'b0,
        MSG_B_ID = 1'b1
    } msg_id_e;

    localparam logic [MSG_DATA_W-1:0] MSG_A_BYTES [MSG_A_LEN] =
        '{8'h47, 8'h75, 8'h61, 8'h74, 8'h65, 8'h6D, 8'h61, 8'h6C, 8'h61};
    localparam logic [MSG_DATA_W-1:0] MSG_B_BYTES [MSG_B_LEN] =
        '{8'h51, 8'h51, 8'h75, 8'h65, 8'h74, 8'h7A, 8'h61};

    // Selects 00/11 map to message A, 01/10 to message B.
    function automatic msg_id_e msg_id(input logic [1:0] sel);
        return (sel[1] ^ sel[0]) ? MSG_B_ID : MSG_A_ID;
    endfunction

    function automatic logic [MSG_IDX_W-1:0] msg_last_idx(input msg_id_e id);
        return (id == MSG_A_ID) ? MSG_IDX_W'(MSG_A_LEN - 1) : MSG_IDX_W'(MSG_B_LEN - 1);
    endfunction

    function automatic logic [MSG_DATA_W-1:0] msg_byte(input msg_id_e id,
                                                       input logic [MSG_IDX_W-1:0] idx);
        logic [MSG_DATA_W-1:0] b;
        b = '0;
        if (id == MSG_A_ID) begin
            for (int unsigned i = 0; i < MSG_A_LEN; i++)
                if (MSG_IDX_W'(i) == idx) b = MSG_A_BYTES[i];
        end else begin
            for (int unsigned i = 0; i < MSG_B_LEN; i++)
                if (MSG_IDX_W'(i) == idx) b = MSG_B_BYTES[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/msg_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above rr_ptr, wrapping.
module msg_rr_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] rr_ptr_i,
    output logic [NREQ-1:0]  winner_oh_o,
    output logic [PTR_W-1:0] winner_idx_o
);

    logic             found;
    logic [PTR_W-1:0] pos;

    always_comb begin
        winner_oh_o  = '0;
        winner_idx_o = '0;
        found        = 1'b0;
        pos          = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            pos = PTR_W'((32'(rr_ptr_i) + k) % NREQ);
            if (!found && req_i[pos]) begin
                found            = 1'b1;
                winner_oh_o[pos] = 1'b1;
                winner_idx_o     = pos;
            end
        end
    end

endmodule

// File: rtl/msg_stream_arbiter.sv
// Round-robin shared ASCII message streamer with valid/ready output and sof/eof markers.
// Optional MSG_ABORT_EN: owner dropping its request mid-stream ends the message early.
module msg_stream_arbiter
    import msg_pkg::*;
#(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IDX_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] req_sel,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic [DATA_W-1:0] char_out,
    output logic              char_valid,
    input  logic              char_ready,
    output logic              sof,
    output logic              eof,
    output logic              done
`ifdef MSG_ABORT_EN
    ,
    output logic              aborted
`endif
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]  owner_q, owner_d;
    logic [1:0]        sel_q, sel_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] char_q, char_d;
    logic              valid_q, valid_d;
    logic              sof_q, sof_d;
    logic              eof_q, eof_d;
    logic              done_q, done_d;
`ifdef MSG_ABORT_EN
    logic              aborted_q, aborted_d;
`endif

    logic [NREQ-1:0]   win_oh;
    logic [PTR_W-1:0]  win_idx;
    logic [1:0]        win_sel;
    msg_id_e           cur_id;
    logic [IDX_W-1:0]  last_idx;
    logic [IDX_W-1:0]  idx_inc;
    logic              xfer;
    logic              abort_c;

    msg_rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req_i        (req),
        .rr_ptr_i     (rr_ptr_q),
        .winner_oh_o  (win_oh),
        .winner_idx_o (win_idx)
    );

    // Select code of the arbitration winner.
    always_comb begin
        win_sel = 2'b00;
        for (int unsigned i = 0; i < NREQ; i++)
            if (PTR_W'(i) == win_idx) win_sel = req_sel[2*i +: 2];
    end

    assign cur_id   = msg_id(sel_q);
    assign last_idx = IDX_W'(msg_last_idx(cur_id));
    assign idx_inc  = IDX_W'(idx_q + 1'b1);
    assign xfer     = valid_q & char_ready;

`ifdef MSG_ABORT_EN
    assign abort_c = ~req[owner_q];
`else
    assign abort_c = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        sel_d     = sel_q;
        idx_d     = idx_q;
        grant_d   = grant_q;
        busy_d    = busy_q;
        char_d    = char_q;
        valid_d   = valid_q;
        sof_d     = sof_q;
        eof_d     = eof_q;
        done_d    = 1'b0;
`ifdef MSG_ABORT_EN
        aborted_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_STREAM;
                    owner_d = win_idx;
                    sel_d   = win_sel;
                    idx_d   = '0;
                    grant_d = win_oh;
                    busy_d  = 1'b1;
                    char_d  = DATA_W'(msg_byte(msg_id(win_sel), '0));
                    valid_d = 1'b1;
                    sof_d   = 1'b1;
                    eof_d   = 1'b0;
                end
            end
            ST_STREAM: begin
                // Final transfer or abort both end the message through DONE.
                if (abort_c || (xfer && idx_q == last_idx)) begin
                    state_d   = ST_DONE;
                    valid_d   = 1'b0;
                    sof_d     = 1'b0;
                    eof_d     = 1'b0;
                    grant_d   = '0;
                    done_d    = 1'b1;
                    rr_ptr_d  = PTR_W'((32'(owner_q) + 32'd1) % NREQ);
`ifdef MSG_ABORT_EN
                    aborted_d = abort_c;
`endif
                end else if (xfer) begin
                    idx_d  = idx_inc;
                    char_d = DATA_W'(msg_byte(cur_id, MSG_IDX_W'(idx_inc)));
                    sof_d  = 1'b0;
                    eof_d  = (idx_inc == last_idx);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            sel_q     <= '0;
            idx_q     <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            char_q    <= '0;
            valid_q   <= 1'b0;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
            done_q    <= 1'b0;
`ifdef MSG_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            sel_q     <= sel_d;
            idx_q     <= idx_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            char_q    <= char_d;
            valid_q   <= valid_d;
            sof_q     <= sof_d;
            eof_q     <= eof_d;
            done_q    <= done_d;
`ifdef MSG_ABORT_EN
            aborted_q <= aborted_d;
`endif
        end
    end

    assign grant      = grant_q;
    assign busy       = busy_q;
    assign char_out   = char_q;
    assign char_valid = valid_q;
    assign sof        = sof_q;
    assign eof        = eof_q;
    assign done       = done_q;
`ifdef MSG_ABORT_EN
    assign aborted    = aborted_q;
`endif

endmodule

// File: doc/msg_stream_arbiter.md
Name: msg_stream_arbiter

Overview:
- Shares one ASCII message generator between NREQ requesters.
- Each requester requests one of two stored messages through a 2-bit select code.
- A round-robin arbiter picks one requester and the block streams that message one byte at a time over a valid/ready interface, with start and end markers.
- Sits between the requesting control logic and the character output stage; it is the sequencer for the message datapath.

Parameters:
NREQ, 4, number of requesters
DATA_W, 8, character width (fixed ASCII)
IDX_W, 4, character index counter width (must hold max length - 1 = 8)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
req  in  NREQ  per-requester request level
req_sel  in  2*NREQ  packed 2-bit select per requester; bits [2i+1:2i] belong to requester i
grant  out  NREQ  one-hot grant of the current owner; all zero when idle
busy  out  1  high in STREAM and DONE states
char_out  out  DATA_W  current character, registered
char_valid  out  1  char_out is valid
char_ready  in  1  downstream accepts char_out when char_valid is also high
sof  out  1  high with the first character of a message
eof  out  1  high with the last character of a message
done  out  1  one-cycle pulse after the last character is accepted

Behaviour:
- Reset values: all outputs 0, state IDLE, rr_ptr 0, idx 0, latched select 0. Reset is asynchronous and acts mid-operation; the current stream is discarded with no eof and no done.
- Message table, selected by the latched 2-bit select:
  - MSG_A, select 00 or 11, 9 bytes: 47 75 61 74 65 6D 61 6C 61.
  - MSG_B, select 01 or 10, 7 bytes: 51 51 75 65 74 7A 61.
- FSM states: IDLE, STREAM, DONE.
- IDLE:
  - If req != 0, the arbiter picks the first asserted request searching upward from rr_ptr, wrapping at NREQ.
  - At the next edge: grant = one-hot winner, its req_sel is latched, idx = 0, char_out = byte 0, char_valid = 1, sof = 1, state goes to STREAM.
  - Latency from req high to char_valid high is 1 cycle.
- STREAM:
  - A transfer happens when char_valid && char_ready.
  - While char_valid && !char_ready, char_out, sof and eof hold stable.
  - On a transfer with idx < len-1: idx+1, char_out = next byte, sof = 0, eof = (idx+1 == len-1).
  - On a transfer with idx == len-1: char_valid = 0, eof = 0, state goes to DONE.
- DONE (1 cycle): done = 1, grant = 0, rr_ptr = winner+1 (mod NREQ), then IDLE.
  - busy drops when the state returns to IDLE.
  - Minimum gap between messages is 2 cycles (DONE, then IDLE).
- Request sampling:
  - req and req_sel are sampled only in IDLE.
  - Changes during STREAM or DONE are ignored (unless the optional feature is enabled).
  - New requests in DONE wait for IDLE.
- Length: idx never exceeds len-1 and wraps to 0 only via a new grant.
- Single requester asserting continuously is granted back-to-back, every len+2 cycles at full ready.
- A one-cycle sof+eof message cannot occur (both messages have length > 1).

Optional Feature:
MSG_ABORT_EN
- Defined: in STREAM, if req[owner] is low on a clock edge, the next state is DONE.
  - char_valid drops with no eof, done pulses, and an extra output aborted (1 bit, reset 0) pulses together with done.
  - rr_ptr advances as in normal completion.
- Undefined: req deassertion during STREAM is ignored, the message always completes, and the aborted port is absent.

Decomposition:
- Package msg_pkg holds:
  - state enum (IDLE, STREAM, DONE);
  - MSG_A_LEN = 9 and MSG_B_LEN = 7;
  - the two byte arrays;
  - a function mapping a 2-bit select to message id, and message id plus index to byte.
- One sub-module, msg_rr_arbiter: combinational round-robin pick. It takes req and rr_ptr and returns a one-hot winner and a winner index.
- All state, index and output registers live in msg_stream_arbiter.

Test Plan:
1. Assert reset mid-clock with random inputs -> all outputs 0 immediately, without waiting for an edge. After release, idle with grant = 0.
2. req = 0001, req_sel = 00, char_ready = 1 -> grant = 0001 one cycle later. Bytes 47,75,61,74,65,6D,61,6C,61 on 9 consecutive cycles, sof on the first, eof on the ninth, done the next cycle, then grant = 0.
3. req = 0010, select 10, char_ready toggling 1/0 -> char_out stable while not ready. Exactly 7 transfers 51,51,75,65,74,7A,61, eof with 61.
4. req = 1111 held, char_ready = 1 -> grant sequence 0001, 0010, 0100, 1000, 0001. Each stream is preceded by a 2-cycle gap.
5. Reset asserted after 3 accepted bytes -> no eof and no done, rr_ptr = 0. A new req = 0100 restarts at byte 0 with sof.
6. With MSG_ABORT_EN: drop req of the owner after 2 bytes -> char_valid low next cycle, done and aborted pulse together, no eof. Without the macro the full message completes.
